tetris_move_scheduler: RTL
==========================

Name: tetris_move_scheduler

Overview:
- Sits between the PS/2 keyboard decoder and the Tetris game engine.
- Latches one-cycle action pulses from the decoder (left, right, down, rotate) and generates level-dependent gravity ticks.
- Arbitrates user and gravity requests into a single valid/ready command stream, one command per engine step.

Parameters:
- GRAVITY_BASE, 50_000_000: gravity period in clk cycles at level 0.
- GRAVITY_STEP, 4_000_000: cycles removed from the period per level.
- GRAVITY_MIN, 5_000_000: floor on the gravity period.
- TW, 32: gravity counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- game_run  in  1  1 = scheduling active; 0 = flush and hold
- level  in  4  current game level (0..15)
- move_left  in  1  one-cycle pulse from decoder
- move_right  in  1  one-cycle pulse from decoder
- move_down  in  1  one-cycle pulse from decoder (soft drop)
- rotate  in  1  one-cycle pulse from decoder
- cmd_valid  out  1  command available
- cmd_ready  in  1  engine accepts command
- cmd  out  3  1=LEFT, 2=RIGHT, 3=ROTATE, 4=SOFT_DROP, 5=GRAVITY, 0 when idle
- busy  out  1  any request pending or cmd_valid high

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Outputs: cmd_valid=0, cmd=0, busy=0.
  - Internal: pending flags cleared, gravity counter=0, state IDLE.
  - Applies mid-handshake too; cmd_valid may drop without acceptance.
- Pending flags: one per request type (L, R, ROT, DN, GRV).
  - Pulses are sampled every cycle regardless of state.
  - Flags set on the cycle after the pulse.
- Direction rules:
  - move_left and move_right in the same cycle: both ignored.
  - A left pulse clears pending R; a right pulse clears pending L (latest wins).
- Gravity period:
  - P = GRAVITY_BASE - level*GRAVITY_STEP, computed at TW+4 bits.
  - If the subtraction underflows or P < GRAVITY_MIN, then P = GRAVITY_MIN.
  - While game_run=1, the counter increments each cycle.
  - When counter >= P-1: counter <= 0 and GRV is set.
  - The >= compare handles a mid-count level increase: fires on the next cycle.
- Soft-drop merge: when SOFT_DROP is accepted, GRV is cleared and the gravity counter resets to 0.
- FSM:
  - IDLE: if any flag is set, select the highest priority (ROT > L > R > DN > GRV), drive cmd and cmd_valid=1 next cycle, go to ISSUE.
  - ISSUE: cmd and cmd_valid hold stable until cmd_ready=1. On the accept edge, clear the selected flag and return to IDLE.
  - Set wins: a same-type pulse on the accept cycle re-sets the flag.
- Throughput:
  - Latency: pulse at cycle N gives cmd_valid=1 at N+2 (flag at N+1, issue at N+2).
  - Back-to-back: with cmd_ready held high, one accepted command per 2 cycles.
- game_run=0:
  - All flags cleared, counter held at 0, pulses ignored.
  - cmd_valid deasserts next cycle, FSM returns to IDLE. The engine tolerates the abort.
- busy = OR of flags | cmd_valid.

Optional Feature:
- Macro: MOVE_QUEUE_EN.
- Defined: L and R flags become 2-bit saturating counters (max 3).
  - Each accepted LEFT/RIGHT decrements by 1.
  - Pulse and accept on the same cycle leave the count unchanged.
  - An opposite-direction pulse zeroes the other counter.
  - Pulses beyond 3 are dropped.
- Undefined: single-bit flags; repeat presses while pending are merged.

Test Plan:
- Reset: hold rst_n=0 with pulses and cmd_ready toggling -> cmd_valid=0, cmd=0, busy=0. After release with no stimulus -> first GRAVITY cmd=5 exactly P cycles after game_run=1 (level 0: 50_000_000; shrink via parameter override in the bench).
- Priority: rotate and move_left pulsed same cycle, cmd_ready=1 -> cmd=3 accepted, then cmd=1 two cycles later, then idle.
- Backpressure: move_right pulse, cmd_ready=0 for 10 cycles -> cmd=2, cmd_valid held stable all 10 cycles; a move_left pulse during the wait does not alter cmd. After accept, L pending -> cmd=1.
- Soft-drop merge:
  - Gravity pending and move_down pulse -> single cmd=4, no cmd=5 follows.
  - Counter restarts: next GRAVITY exactly P cycles later.
- Level clamp: level=15 (15*4M > 50M) -> gravity period equals GRAVITY_MIN=5_000_000. Raising level mid-count with counter > new P -> GRAVITY on the next cycle.
- game_run drop while cmd_valid=1 -> cmd_valid=0 next cycle, busy=0, pending cleared. With MOVE_QUEUE_EN, 5 left pulses -> exactly 3 LEFT cmds.

Source files
------------

// File: rtl/tetris_move_scheduler_if.sv
// tetris_move_scheduler_if
//   Command stream between the move scheduler and the Tetris game engine.
//   One command is transferred on each clock edge where cmd_valid and
//   cmd_ready are both high.
//
//   cmd_valid  scheduler -> engine   command available
//   cmd        scheduler -> engine   1=LEFT 2=RIGHT 3=ROTATE 4=SOFT_DROP 5=GRAVITY, 0 idle
//   cmd_ready  engine -> scheduler   engine accepts the command
//
//   master: the scheduler side; slave: the engine side.
interface tetris_move_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd;

    modport master (output cmd_valid, output cmd, input cmd_ready);
    modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/tetris_move_scheduler.sv
// tetris_move_scheduler
//   Sits between the PS/2 keyboard decoder and the game engine. Latches the
//   decoder's one-cycle action pulses, generates level-dependent gravity
//   ticks and arbitrates everything into a single valid/ready command stream
//   (priority ROTATE > LEFT > RIGHT > SOFT_DROP > GRAVITY).
//
//   Ports:
//     clk         system clock
//     rst_n       synchronous reset, active-low
//     game_run    1 = scheduling active, 0 = flush and hold
//     level       current game level (0..15), shortens the gravity period
//     move_left, move_right, move_down, rotate   one-cycle decoder pulses
//     cmd_if      master side of the command stream (cmd_valid, cmd, cmd_ready)
//     busy        any request pending or a command on offer
//
//   Optional feature, macro MOVE_QUEUE_EN:
//     defined   - LEFT/RIGHT requests are 2-bit saturating counts (up to 3
//                 queued presses, one consumed per accepted command)
//     undefined - LEFT/RIGHT are single flags, repeat presses merge
module tetris_move_scheduler #(
    parameter int unsigned GRAVITY_BASE = 50_000_000,
    parameter int unsigned GRAVITY_STEP = 4_000_000,
    parameter int unsigned GRAVITY_MIN  = 5_000_000,
    parameter int unsigned TW           = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           game_run,
    input  logic [3:0]                     level,
    input  logic                           move_left,
    input  logic                           move_right,
    input  logic                           move_down,
    input  logic                           rotate,
    tetris_move_scheduler_if.master        cmd_if,
    output logic                           busy
);

`ifdef MOVE_QUEUE_EN
    localparam int unsigned QW = 2;
`else
    localparam int unsigned QW = 1;
`endif
    localparam int unsigned PW = TW + 4;
    localparam logic [QW-1:0] Q_MAX = '1;

    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_LEFT  = 3'd1;
    localparam logic [2:0] CMD_RIGHT = 3'd2;
    localparam logic [2:0] CMD_ROT   = 3'd3;
    localparam logic [2:0] CMD_DOWN  = 3'd4;
    localparam logic [2:0] CMD_GRAV  = 3'd5;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state;
    logic [QW-1:0]   cnt_l;
    logic [QW-1:0]   cnt_r;
    logic            flag_rot;
    logic            flag_dn;
    logic            flag_grv;
    logic [TW-1:0]   grav_cnt;
    logic            cmd_valid_q;
    logic [2:0]      cmd_q;

    logic [PW-1:0]   prod;
    logic [PW-1:0]   diff;
    logic [PW-1:0]   period;
    logic            grav_fire;
    logic [2:0]      sel;
    logic            any_flag;
    logic            accept;
    logic            accept_l;
    logic            accept_r;
    logic            accept_rot;
    logic            accept_dn;
    logic            accept_grv;
    logic            left_only;
    logic            right_only;

    assign cmd_if.cmd_valid = cmd_valid_q;
    assign cmd_if.cmd       = cmd_q;

    // Gravity period, clamped to GRAVITY_MIN when the level product exceeds
    // the base (underflow) or leaves too short a period. The >= compare lets a
    // mid-count level increase fire on the very next cycle.
    always_comb begin
        prod   = PW'(level) * PW'(GRAVITY_STEP);
        diff   = PW'(GRAVITY_BASE) - prod;
        period = diff;
        if ((prod > PW'(GRAVITY_BASE)) || (diff < PW'(GRAVITY_MIN)))
            period = PW'(GRAVITY_MIN);
        grav_fire = ({4'b0000, grav_cnt} >= (period - PW'(1)));
    end

    // Fixed-priority pick of the next request to offer.
    always_comb begin
        sel = CMD_NONE;
        if (flag_rot)
            sel = CMD_ROT;
        else if (cnt_l != '0)
            sel = CMD_LEFT;
        else if (cnt_r != '0)
            sel = CMD_RIGHT;
        else if (flag_dn)
            sel = CMD_DOWN;
        else if (flag_grv)
            sel = CMD_GRAV;
    end

    assign any_flag   = flag_rot | (cnt_l != '0) | (cnt_r != '0) | flag_dn | flag_grv;
    assign busy       = any_flag | cmd_valid_q;

    assign accept     = (state == ISSUE) && cmd_if.cmd_ready;
    assign accept_l   = accept && (cmd_q == CMD_LEFT);
    assign accept_r   = accept && (cmd_q == CMD_RIGHT);
    assign accept_rot = accept && (cmd_q == CMD_ROT);
    assign accept_dn  = accept && (cmd_q == CMD_DOWN);
    assign accept_grv = accept && (cmd_q == CMD_GRAV);

    // Simultaneous left+right presses cancel each other out.
    assign left_only  = move_left & ~move_right;
    assign right_only = move_right & ~move_left;

    // Reset and game_run=0 have the same effect: everything is flushed and
    // the FSM goes idle, even in the middle of a handshake.
    // Direction counts: the opposite direction zeroes the count, a press
    // increments (saturating), an accept decrements; press+accept on the same
    // edge leaves the count as is. The != 0 guards cover a request that was
    // cancelled by the opposite direction while already on offer.
    always_ff @(posedge clk) begin
        if (!rst_n || !game_run) begin
            state       <= IDLE;
            cnt_l       <= '0;
            cnt_r       <= '0;
            flag_rot    <= 1'b0;
            flag_dn     <= 1'b0;
            flag_grv    <= 1'b0;
            grav_cnt    <= '0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_NONE;
        end else begin
            if (accept_dn) begin
                grav_cnt <= '0;
                flag_grv <= 1'b0;
            end else if (grav_fire) begin
                grav_cnt <= '0;
                flag_grv <= 1'b1;
            end else begin
                grav_cnt <= grav_cnt + TW'(1);
                if (accept_grv)
                    flag_grv <= 1'b0;
            end

            if (rotate)
                flag_rot <= 1'b1;
            else if (accept_rot)
                flag_rot <= 1'b0;

            if (move_down)
                flag_dn <= 1'b1;
            else if (accept_dn)
                flag_dn <= 1'b0;

            if (right_only)
                cnt_l <= '0;
            else if (left_only) begin
                if (!(accept_l && (cnt_l != '0)) && (cnt_l != Q_MAX))
                    cnt_l <= cnt_l + QW'(1);
            end else if (accept_l && (cnt_l != '0))
                cnt_l <= cnt_l - QW'(1);

            if (left_only)
                cnt_r <= '0;
            else if (right_only) begin
                if (!(accept_r && (cnt_r != '0)) && (cnt_r != Q_MAX))
                    cnt_r <= cnt_r + QW'(1);
            end else if (accept_r && (cnt_r != '0))
                cnt_r <= cnt_r - QW'(1);

            case (state)
                IDLE: begin
                    if (any_flag) begin
                        cmd_q       <= sel;
                        cmd_valid_q <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_if.cmd_ready) begin
                        cmd_q       <= CMD_NONE;
                        cmd_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
